// File: rtl/cache_fill_fsm_pkg.sv
// Shared widths, masks and state encoding for the cache block-fill controller.
package cache_fill_fsm_pkg;

  localparam int unsigned ADDR_W      = 16;
  localparam int unsigned BLOCK_WORDS = 8;
  localparam int unsigned IDX_W       = 3;
  localparam int unsigned CNT_W       = IDX_W + 1;

  localparam logic [ADDR_W-1:0] OFFSET_MASK = 16'hFFF0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_t;

  // Byte offset of a 16-bit word slot within the block.
  function automatic logic [ADDR_W-1:0] word_offset(input logic [IDX_W-1:0] idx);
    return ADDR_W'({idx, 1'b0});
  endfunction

endpackage

// File: rtl/cache_fill_fsm_cla.sv
// 16-bit carry-lookahead adder/subtractor built from 4-bit lookahead groups.
module cache_fill_fsm_cla
  import cache_fill_fsm_pkg::*;
(
  input  logic [ADDR_W-1:0] i_a,
  input  logic [ADDR_W-1:0] i_b,
  input  logic              i_sub,
  output logic [ADDR_W-1:0] o_sum
);

  localparam int unsigned GROUPS = ADDR_W / 4;

  always_comb begin : cla
    logic [ADDR_W-1:0] b;
    logic [ADDR_W-1:0] g;
    logic [ADDR_W-1:0] p;
    logic [ADDR_W-1:0] c;
    logic [GROUPS-1:0] gg;
    logic [GROUPS-1:0] gp;
    logic [GROUPS-1:0] gc;
    b  = i_b ^ {ADDR_W{i_sub}};
    g  = i_a & b;
    p  = i_a ^ b;
    c  = '0;
    gg = '0;
    gp = '0;
    gc = '0;
    for (int k = 0; k < GROUPS; k++) begin
      gp[k] = &p[4*k +: 4];
      gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
    end
    // Group carries resolve first, then each group ripples its own 4 bits.
    gc[0] = i_sub;
    for (int k = 0; k < GROUPS - 1; k++) begin
      gc[k+1] = gg[k] | (gp[k] & gc[k]);
    end
    for (int k = 0; k < GROUPS; k++) begin
      c[4*k] = gc[k];
      for (int j = 0; j < 3; j++) begin
        c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
      end
    end
    o_sum = p ^ c;
  end

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: fetches an 8-word block, writes data words, then the tag.
module cache_fill_fsm
  import cache_fill_fsm_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic [ADDR_W-1:0] memory_data,
  input  logic              memory_data_valid,
  output logic              fsm_busy,
  output logic              memory_read_en,
  output logic [ADDR_W-1:0] memory_address,
  output logic              write_data_array,
  output logic [IDX_W-1:0]  data_word_index,
  output logic              write_tag_array
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ADDR_W-1:0]  r_base;
  logic [ADDR_W-1:0]  w_base_nxt;
  logic [CNT_W-1:0]   r_req_cnt;
  logic [CNT_W-1:0]   w_req_nxt;
  logic [IDX_W-1:0]   r_rsp_cnt;
  logic [IDX_W-1:0]   w_rsp_nxt;
  logic [ADDR_W-1:0]  w_addr;
  logic               w_issue;
  logic               w_last;

  // memory_data is consumed by the data array directly, never by this controller.
  logic w_unused_data;
  assign w_unused_data = ^memory_data;

  cache_fill_fsm_cla u_addr_cla (
    .i_a   (r_base),
    .i_b   (word_offset(r_req_cnt[IDX_W-1:0])),
    .i_sub (1'b0),
    .o_sum (w_addr)
  );

  assign w_issue = (r_state == ST_FILL) && (r_req_cnt < CNT_W'(BLOCK_WORDS));
  assign w_last  = (r_state == ST_FILL) && memory_data_valid
                && (r_rsp_cnt == IDX_W'(BLOCK_WORDS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_base    <= '0;
      r_req_cnt <= '0;
      r_rsp_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_base    <= w_base_nxt;
      r_req_cnt <= w_req_nxt;
      r_rsp_cnt <= w_rsp_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_base_nxt       = r_base;
    w_req_nxt        = r_req_cnt;
    w_rsp_nxt        = r_rsp_cnt;
    fsm_busy         = 1'b0;
    memory_read_en   = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    data_word_index  = '0;
    write_tag_array  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Stall is raised in the miss cycle itself; held low while in reset.
        fsm_busy = miss_detected & rst_n;
        if (miss_detected) begin
          w_state_nxt = ST_FILL;
          w_base_nxt  = miss_address & OFFSET_MASK;
          w_req_nxt   = '0;
          w_rsp_nxt   = '0;
        end
      end
      ST_FILL: begin
        fsm_busy         = 1'b1;
        memory_read_en   = w_issue;
        memory_address   = w_addr;
        write_data_array = memory_data_valid;
        data_word_index  = r_rsp_cnt;
        if (w_issue) begin
          w_req_nxt = r_req_cnt + CNT_W'(1);
        end
        if (memory_data_valid) begin
          w_rsp_nxt = r_rsp_cnt + IDX_W'(1);
        end
        if (w_last) begin
          write_tag_array = 1'b1;
          w_state_nxt     = ST_IDLE;
          w_req_nxt       = '0;
          w_rsp_nxt       = '0;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm with a 4-cycle in-order memory model and scoreboard.
module tb_cache_fill_fsm;

  localparam logic [15:0] KEY = 16'h5A5A;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic [15:0] memory_data;
  logic        memory_data_valid;
  logic        fsm_busy;
  logic        memory_read_en;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic [2:0]  data_word_index;
  logic        write_tag_array;

  typedef struct {
    logic [2:0]  idx;
    logic [15:0] data;
    logic        tag;
  } wexp_t;

  typedef struct {
    logic [15:0] addr;
    int          rdy;
  } mreq_t;

  wexp_t       exp_w[$];
  logic [15:0] exp_r[$];
  mreq_t       mq[$];

  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   n_writes = 0;
  int   n_tags   = 0;
  int   tag_cyc  = 0;
  logic gap_mode = 1'b0;
  logic gap_tog  = 1'b0;
  logic inj_valid = 1'b0;
  logic        m_valid;
  logic [15:0] m_data;

  cache_fill_fsm dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data       (memory_data),
    .memory_data_valid (memory_data_valid),
    .fsm_busy          (fsm_busy),
    .memory_read_en    (memory_read_en),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .data_word_index   (data_word_index),
    .write_tag_array   (write_tag_array)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign memory_data       = m_data;
  assign memory_data_valid = m_valid | inj_valid;

  // Memory: fixed 4-cycle latency, in-order; optional one-word-every-other-cycle throttle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_valid <= 1'b0;
      m_data  <= '0;
      gap_tog <= 1'b0;
    end else begin
      mreq_t h;
      if (memory_read_en) mq.push_back('{addr: memory_address, rdy: cyc + 4});
      gap_tog <= ~gap_tog;
      if (mq.size() > 0 && mq[0].rdy <= cyc + 1 && (!gap_mode || gap_tog)) begin
        h = mq.pop_front();
        m_valid <= 1'b1;
        m_data  <= h.addr ^ KEY;
      end else begin
        m_valid <= 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: pop expected reads/writes as the DUT produces them.
  always @(negedge clk) begin
    if (rst_n) begin
      if (memory_read_en) begin
        if (exp_r.size() == 0) check("unexpected_read", 32'(memory_read_en), 32'd0);
        else check("read_addr", 32'(memory_address), 32'(exp_r.pop_front()));
      end
      if (write_data_array) begin
        n_writes++;
        if (exp_w.size() == 0) begin
          check("unexpected_write", 32'(write_data_array), 32'd0);
        end else begin
          wexp_t e;
          e = exp_w.pop_front();
          check("word_index", 32'(data_word_index), 32'(e.idx));
          check("word_data", 32'(memory_data), 32'(e.data));
          check("tag_with_word", 32'(write_tag_array), 32'(e.tag));
        end
      end else if (write_tag_array) begin
        check("tag_without_data", 32'(write_tag_array), 32'd0);
      end
      if (write_tag_array) begin
        n_tags++;
        tag_cyc = cyc;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic push_fill(input logic [15:0] base);
    for (int i = 0; i < 8; i++) begin
      logic [15:0] a;
      a = base + 16'(2 * i);
      exp_r.push_back(a);
      exp_w.push_back('{idx: 3'(i), data: a ^ KEY, tag: (i == 7)});
    end
  endtask

  task automatic start_miss(input logic [15:0] a, output int start_cyc);
    step();
    miss_detected = 1'b1;
    miss_address  = a;
    push_fill(a & 16'hFFF0);
    start_cyc = cyc;
  endtask

  // Runs from the miss cycle to the tag-write cycle, counting busy cycles.
  task automatic wait_fill(input int hold, input logic [15:0] alt, output int busy_cycles);
    int   t0;
    logic done;
    t0 = n_tags;
    done = 1'b0;
    busy_cycles = 0;
    sample();
    if (fsm_busy) busy_cycles++;
    for (int k = 0; k < 80; k++) begin
      if (n_tags != t0) begin
        done = 1'b1;
        break;
      end
      step();
      miss_detected = (k < hold);
      if (k < hold) miss_address = alt;
      sample();
      if (fsm_busy) busy_cycles++;
    end
    check("fill_completes", 32'(done), 32'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check(tag, 32'({fsm_busy, memory_read_en, memory_address, write_data_array,
                    data_word_index, write_tag_array}), 32'd0);
  endtask

  initial begin
    int s;
    int busy;
    int w0;
    int t0;
    int tag1;

    // 1: reset holds every output low even with miss and stale data present
    rst_n = 1'b0;
    miss_detected = 1'b1;
    miss_address  = 16'h1234;
    inj_valid     = 1'b1;
    repeat (3) step();
    sample();
    check_idle_outputs("reset_outputs");
    step();
    rst_n = 1'b1;
    miss_detected = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample();
      check("idle_stale_no_write", 32'(write_data_array), 32'd0);
      check("idle_not_busy", 32'(fsm_busy), 32'd0);
      step();
    end
    inj_valid = 1'b0;
    sample();
    check_idle_outputs("idle_outputs");

    // 2: basic fill at 0x1234
    start_miss(16'h1234, s);
    wait_fill(0, 16'h0, busy);
    check("busy_cycles_basic", 32'(busy), 32'd13);
    check("tag_latency", 32'(tag_cyc - s), 32'd12);
    step();
    miss_detected = 1'b0;
    sample();
    check_idle_outputs("after_fill_idle");
    check("reads_drained", 32'(exp_r.size()), 32'd0);

    // 3: miss address changes during FILL are ignored
    start_miss(16'h1234, s);
    wait_fill(6, 16'hBEEF, busy);
    check("busy_cycles_toggle", 32'(busy), 32'd13);
    repeat (3) begin
      step();
      miss_detected = 1'b0;
      sample();
      check("no_second_fill", 32'(fsm_busy), 32'd0);
    end
    check("writes_drained_toggle", 32'(exp_w.size()), 32'd0);

    // 4: back-to-back misses with no dead cycle
    start_miss(16'h0010, s);
    wait_fill(0, 16'h0, busy);
    check("busy_first_b2b", 32'(busy), 32'd13);
    tag1 = tag_cyc;
    start_miss(16'h0FF8, s);
    wait_fill(0, 16'h0, busy);
    check("busy_second_b2b", 32'(busy), 32'd13);
    check("b2b_tag_spacing", 32'(tag_cyc - tag1), 32'd13);
    step();
    miss_detected = 1'b0;
    sample();
    check("b2b_idle", 32'(fsm_busy), 32'd0);

    // 5: reset after three returned words aborts without a tag write
    w0 = n_writes;
    t0 = n_tags;
    start_miss(16'h2222, s);
    for (int i = 0; i < 40; i++) begin
      step();
      miss_detected = 1'b0;
      sample();
      if (n_writes - w0 >= 3) break;
    end
    check("abort_after_three", 32'(n_writes - w0), 32'd3);
    step();
    rst_n = 1'b0;
    exp_r.delete();
    exp_w.delete();
    sample();
    check_idle_outputs("abort_reset_outputs");
    step();
    rst_n = 1'b1;
    sample();
    check_idle_outputs("abort_idle");
    check("abort_no_tag", 32'(n_tags - t0), 32'd0);
    start_miss(16'h0040, s);
    wait_fill(0, 16'h0, busy);
    check("refill_busy", 32'(busy), 32'd13);
    check("refill_writes_drained", 32'(exp_w.size()), 32'd0);
    step();
    miss_detected = 1'b0;

    // 6: throttled memory still yields exactly 8 words and one tag
    gap_mode = 1'b1;
    w0 = n_writes;
    t0 = n_tags;
    start_miss(16'h3456, s);
    wait_fill(0, 16'h0, busy);
    check("gap_writes", 32'(n_writes - w0), 32'd8);
    check("gap_tags", 32'(n_tags - t0), 32'd1);
    check("gap_busy_longer", 32'(busy > 13), 32'd1);
    step();
    miss_detected = 1'b0;
    sample();
    check("gap_idle", 32'(fsm_busy), 32'd0);
    check("gap_queues_drained", 32'(exp_r.size() + exp_w.size()), 32'd0);
    gap_mode = 1'b0;

    repeat (4) step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
